// File: rtl/glyph_pixel_gen_if.sv
// Request/pixel bus between the display controller and glyph_pixel_gen.
// slave modport: the generator (takes requests, produces pixels).
// master modport: the controller (issues requests, consumes pixels).
//   start/abort            request strobe and cancel
//   char_code/row/scale    glyph code, glyph row 0..15, replication minus 1
//   invert/fg_color/bg_color  colour selection for this request
//   busy/pixel_valid/pixel/done/unsupported  generator status and pixel stream
interface glyph_pixel_gen_if #(
  parameter int unsigned CODE_W  = 7,
  parameter int unsigned COLOR_W = 12,
  parameter int unsigned SCALE_W = 2
);
  logic               start;
  logic [CODE_W-1:0]  char_code;
  logic [3:0]         row;
  logic [SCALE_W-1:0] scale;
  logic               invert;
  logic [COLOR_W-1:0] fg_color;
  logic [COLOR_W-1:0] bg_color;
  logic               abort;
  logic               busy;
  logic               pixel_valid;
  logic [COLOR_W-1:0] pixel;
  logic               done;
  logic               unsupported;

  modport slave (
    input  start, char_code, row, scale, invert, fg_color, bg_color, abort,
    output busy, pixel_valid, pixel, done, unsupported
  );

  modport master (
    output start, char_code, row, scale, invert, fg_color, bg_color, abort,
    input  busy, pixel_valid, pixel, done, unsupported
  );
endinterface

// File: rtl/glyph_pixel_gen.sv
// Looks up one row of an 8x16 glyph and serialises it as colour pixels,
// MSB first, each bit repeated scale+1 times, optionally inverted.
// Ports:
//   clk    system clock, rising edge
//   reset  asynchronous active-high reset
//   bus    glyph_pixel_gen_if.slave request/pixel bus
module glyph_pixel_gen #(
  parameter int unsigned CODE_W  = 7,
  parameter int unsigned COLOR_W = 12,
  parameter int unsigned SCALE_W = 2
) (
  input  logic               clk,
  input  logic               reset,
  glyph_pixel_gen_if.slave   bus
);

  localparam int unsigned BIT_W = 3;

  typedef enum logic [1:0] {IDLE, FETCH, SHIFT} state_t;

  state_t             state, state_d;
  logic [7:0]         rom_q, rom_d;
  logic               unsup_q, unsup_d;
  logic               inv_l, inv_d;
  logic [COLOR_W-1:0] fg_l, fg_d, bg_l, bg_d;
  logic [SCALE_W-1:0] scale_l, scale_d;
  logic [7:0]         shreg, shreg_d;
  logic [BIT_W-1:0]   bit_cnt, bit_d;
  logic [SCALE_W-1:0] rep_cnt, rep_d;
  logic               busy_d, valid_d, done_d;
  logic [COLOR_W-1:0] pixel_d;
  logic [8:0]         lookup;

  // Font table: returns {defined, row_byte}; undefined codes give a blank row.
  function automatic logic [8:0] glyph_lookup(input logic [CODE_W-1:0] code,
                                              input logic [3:0] r);
    logic [127:0] g;
    logic         ok;
    g  = '0;
    ok = 1'b1;
    case (32'(code))
      32'h00, 32'h20: g = '0;
      32'h2A: g = 128'h0000_0000_0066_3CFF_3C66_0000_0000_0000;
      32'h2B: g = 128'h0000_0000_0018_187E_1818_0000_0000_0000;
      32'h2D: g = 128'h0000_0000_0000_00FE_0000_0000_0000_0000;
      32'h2F: g = 128'h0000_0000_0206_0C18_3060_C080_0000_0000;
      32'h30: g = 128'h0000_7CC6_C6CE_DEF6_E6C6_C67C_0000_0000;
      32'h31: g = 128'h0000_1838_7818_1818_1818_187E_0000_0000;
      32'h32: g = 128'h0000_7CC6_060C_1830_60C0_C6FE_0000_0000;
      32'h33: g = 128'h0000_7CC6_0606_3C06_0606_C67C_0000_0000;
      32'h34: g = 128'h0000_0C1C_3C6C_CCFE_0C0C_0C1E_0000_0000;
      32'h35: g = 128'h0000_FEC0_C0C0_FC06_0606_C67C_0000_0000;
      32'h36: g = 128'h0000_3860_C0C0_FCC6_C6C6_C67C_0000_0000;
      32'h37: g = 128'h0000_FEC6_0606_0C18_3030_3030_0000_0000;
      32'h38: g = 128'h0000_7CC6_C6C6_7CC6_C6C6_C67C_0000_0000;
      32'h39: g = 128'h0000_7CC6_C6C6_7E06_0606_0C78_0000_0000;
      default: ok = 1'b0;
    endcase
    // Row 0 is the most significant byte.
    return {ok, g[{4'(4'd15 - r), 3'b000} +: 8]};
  endfunction

  // State and datapath registers; outputs are registered from next-state values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state           <= IDLE;
      rom_q           <= '0;
      unsup_q         <= 1'b0;
      inv_l           <= 1'b0;
      fg_l            <= '0;
      bg_l            <= '0;
      scale_l         <= '0;
      shreg           <= '0;
      bit_cnt         <= '0;
      rep_cnt         <= '0;
      bus.busy        <= 1'b0;
      bus.pixel_valid <= 1'b0;
      bus.pixel       <= '0;
      bus.done        <= 1'b0;
      bus.unsupported <= 1'b0;
    end else begin
      state           <= state_d;
      rom_q           <= rom_d;
      unsup_q         <= unsup_d;
      inv_l           <= inv_d;
      fg_l            <= fg_d;
      bg_l            <= bg_d;
      scale_l         <= scale_d;
      shreg           <= shreg_d;
      bit_cnt         <= bit_d;
      rep_cnt         <= rep_d;
      bus.busy        <= busy_d;
      bus.pixel_valid <= valid_d;
      bus.pixel       <= pixel_d;
      bus.done        <= done_d;
      bus.unsupported <= unsup_d;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d = state;
    rom_d   = rom_q;
    unsup_d = unsup_q;
    inv_d   = inv_l;
    fg_d    = fg_l;
    bg_d    = bg_l;
    scale_d = scale_l;
    shreg_d = shreg;
    bit_d   = bit_cnt;
    rep_d   = rep_cnt;
    lookup  = glyph_lookup(bus.char_code, bus.row);

    case (state)
      IDLE: begin
        // abort wins over a simultaneous start
        if (bus.start && !bus.abort) begin
          rom_d   = lookup[7:0];
          unsup_d = !lookup[8];
          inv_d   = bus.invert;
          fg_d    = bus.fg_color;
          bg_d    = bus.bg_color;
          scale_d = bus.scale;
          state_d = FETCH;
        end
      end
      FETCH: begin
        if (bus.abort) begin
          unsup_d = 1'b0;
          state_d = IDLE;
        end else begin
          shreg_d = rom_q;
          bit_d   = BIT_W'(7);
          rep_d   = scale_l;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (bus.abort || (bit_cnt == '0 && rep_cnt == '0)) begin
          unsup_d = 1'b0;
          state_d = IDLE;
        end else if (rep_cnt != '0) begin
          rep_d = rep_cnt - SCALE_W'(1);
        end else begin
          shreg_d = {shreg[6:0], 1'b0};
          rep_d   = scale_l;
          bit_d   = bit_cnt - BIT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d  = (state_d != IDLE);
    valid_d = (state_d == SHIFT);
    done_d  = valid_d && (bit_d == '0) && (rep_d == '0);
    pixel_d = '0;
    if (valid_d) pixel_d = (shreg_d[7] ^ inv_d) ? fg_d : bg_d;
  end

endmodule

// File: tb/tb_glyph_pixel_gen.sv
module tb_glyph_pixel_gen;
  localparam int unsigned CODE_W  = 7;
  localparam int unsigned COLOR_W = 12;
  localparam int unsigned SCALE_W = 2;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  glyph_pixel_gen_if #(.CODE_W(CODE_W), .COLOR_W(COLOR_W), .SCALE_W(SCALE_W)) bus ();
  glyph_pixel_gen #(.CODE_W(CODE_W), .COLOR_W(COLOR_W), .SCALE_W(SCALE_W)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0]  code;
    logic [3:0]  row;
    logic [1:0]  scale;
    logic        inv;
    logic [11:0] fg;
    logic [11:0] bg;
    logic [7:0]  exp_row;
    logic        exp_unsup;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_idle(input string name);
    chk({name, "_valid"}, 32'(bus.pixel_valid), 32'd0);
    chk({name, "_busy"},  32'(bus.busy),        32'd0);
    chk({name, "_done"},  32'(bus.done),        32'd0);
    chk({name, "_pixel"}, 32'(bus.pixel),       32'd0);
    chk({name, "_unsup"}, 32'(bus.unsupported), 32'd0);
  endtask

  task automatic set_req(input vec_t v);
    bus.char_code = 7'(v.code);
    bus.row       = v.row;
    bus.scale     = v.scale;
    bus.invert    = v.inv;
    bus.fg_color  = v.fg;
    bus.bg_color  = v.bg;
  endtask

  // Issue a request at the current negedge and check the whole pixel stream.
  // pulse_k: pixel index at which a stray start is driven (-1 = none).
  // abort_k: pixel index after which abort is driven (-1 = none).
  task automatic run_req(input vec_t v, input int pulse_k, input int abort_k);
    int          len;
    int          b;
    logic [11:0] exp_px;
    len = 8 * (int'(v.scale) + 1);
    set_req(v);
    bus.start = 1'b1;
    @(negedge clk);
    // Scramble request inputs: only the latched copies may matter now.
    bus.start     = 1'b0;
    bus.char_code = 7'h41;
    bus.row       = ~v.row;
    bus.scale     = ~v.scale;
    bus.invert    = ~v.inv;
    bus.fg_color  = 12'h5A5;
    bus.bg_color  = 12'hA5A;
    chk("fetch_busy",  32'(bus.busy),        32'd1);
    chk("fetch_valid", 32'(bus.pixel_valid), 32'd0);
    for (int k = 0; k < len; k++) begin
      @(negedge clk);
      bus.start = 1'b0;
      b = 7 - k / (int'(v.scale) + 1);
      exp_px = (v.exp_row[b] ^ v.inv) ? v.fg : v.bg;
      chk("px_valid", 32'(bus.pixel_valid), 32'd1);
      chk("px_value", 32'(bus.pixel),       32'(exp_px));
      chk("px_done",  32'(bus.done),        32'(k == len - 1));
      chk("px_busy",  32'(bus.busy),        32'd1);
      chk("px_unsup", 32'(bus.unsupported), 32'(v.exp_unsup));
      if (k == pulse_k) begin
        bus.start     = 1'b1;
        bus.char_code = 7'h31;
        bus.row       = 4'd2;
        bus.scale     = 2'd3;
      end
      if (k == abort_k) begin
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        chk_idle("abort");
        return;
      end
    end
    @(negedge clk);
    bus.start = 1'b0;
    chk_idle("post");
  endtask

  vec_t tmp;

  initial begin
    vecs[0] = '{8'h30, 4'd5,  2'd0, 1'b0, 12'hFFF, 12'h000, 8'hCE, 1'b0};
    vecs[1] = '{8'h2B, 4'd7,  2'd1, 1'b1, 12'hF00, 12'h00F, 8'h7E, 1'b0};
    vecs[2] = '{8'h41, 4'd3,  2'd3, 1'b0, 12'hABC, 12'h123, 8'h00, 1'b1};
    vecs[3] = '{8'h2D, 4'd7,  2'd2, 1'b0, 12'h0F0, 12'h001, 8'hFE, 1'b0};
    vecs[4] = '{8'h00, 4'd0,  2'd0, 1'b1, 12'h0F0, 12'h000, 8'h00, 1'b0};
    vecs[5] = '{8'h7F, 4'd15, 2'd0, 1'b0, 12'h777, 12'h222, 8'h00, 1'b1};
    vecs[6] = '{8'h39, 4'd6,  2'd0, 1'b0, 12'hFFF, 12'h000, 8'h7E, 1'b0};
    vecs[7] = '{8'h2F, 4'd4,  2'd1, 1'b0, 12'h888, 12'h111, 8'h02, 1'b0};

    reset     = 1'b1;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    set_req(vecs[0]);
    @(negedge clk);
    @(negedge clk);
    chk_idle("reset");
    reset = 1'b0;
    @(negedge clk);

    // Table: back-to-back requests, each starting the cycle after the last done.
    foreach (vecs[i]) run_req(vecs[i], -1, -1);

    // Stray start during a request is ignored.
    run_req(vecs[0], 2, -1);
    // Start coinciding with done is ignored (post check sees busy=0).
    run_req(vecs[0], 7, -1);

    // abort at 3rd pixel of an unsupported request.
    tmp = '{8'h41, 4'd3, 2'd0, 1'b0, 12'hFFF, 12'h000, 8'h00, 1'b1};
    run_req(tmp, -1, 2);
    @(negedge clk);
    chk_idle("abort_after");

    // abort together with start in IDLE: not accepted.
    set_req(vecs[0]);
    bus.start = 1'b1;
    bus.abort = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.abort = 1'b0;
    chk_idle("abort_start");
    @(negedge clk);
    chk_idle("abort_start2");

    // Reset mid-request: outputs clear asynchronously.
    tmp = '{8'h38, 4'd4, 2'd1, 1'b0, 12'hFFF, 12'h000, 8'hC6, 1'b0};
    set_req(tmp);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("pre_reset_valid", 32'(bus.pixel_valid), 32'd1);
    #2 reset = 1'b1;
    #1 chk_idle("async_reset");
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk_idle("after_reset");

    // '1' row 2 renders normally after reset.
    tmp = '{8'h31, 4'd2, 2'd0, 1'b0, 12'hFFF, 12'h000, 8'h18, 1'b0};
    run_req(tmp, -1, -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
